// File: rtl/sysmgr_reboot_pkg.sv
// Shared types and constants for the reboot controller: state encoding, request modes,
// and the width helper for the reset-pulse counter.
package sysmgr_reboot_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_FIRE  = 2'd2,
      ST_BOOT  = 2'd3
   } state_e;

   localparam logic MODE_RST  = 1'b0;
   localparam logic MODE_BOOT = 1'b1;

   function automatic int pulse_cnt_w(input int pulse_len);
      return $clog2(pulse_len + 1);
   endfunction

endpackage

// File: rtl/sysmgr_reboot_if.sv
// Request/status bundle between the logic domain and the reboot controller.
interface sysmgr_reboot_if #(
   parameter int DELAY_W = 16
);
   logic               req_trig;
   logic               req_cancel;
   logic               req_mode;
   logic [1:0]         req_sel;
   logic [DELAY_W-1:0] req_delay;
   logic               busy;
   logic               pll_rst_out;
   logic [1:0]         boot_sel;
   logic               boot_trig;

   modport master (
      output req_trig, req_cancel, req_mode, req_sel, req_delay,
      input  busy, pll_rst_out, boot_sel, boot_trig
   );

   modport slave (
      input  req_trig, req_cancel, req_mode, req_sel, req_delay,
      output busy, pll_rst_out, boot_sel, boot_trig
   );
endinterface

// File: rtl/sysmgr_reboot_sync.sv
// Two-flop synchronizer for an asynchronous level plus a one-cycle rising-edge pulse.
module sysmgr_reboot_sync (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic rise_pulse
);
   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= async_in;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rise_pulse = sync_q & ~prev_q;

endmodule

// File: rtl/sysmgr_reboot_ctrl.sv
// Reboot controller: synchronized trig/cancel, cancellable hold-off, fixed-width PLL reset pulse.
// Warmboot path (BOOT state, SB_WARMBOOT) is built only when SYSMGR_REBOOT_WARMBOOT_EN is defined.
//
//  state | meaning
//  IDLE  | no request pending, pll_rst_out low
//  ARMED | hold-off counting down, cancellable
//  FIRE  | pll_rst_out high for PULSE_LEN cycles
//  BOOT  | warmboot select/trigger driven, held until rst
module sysmgr_reboot_ctrl
   import sysmgr_reboot_pkg::*;
#(
   parameter int DELAY_W   = 16,
   parameter int PULSE_LEN = 16
) (
   input  logic           clk,
   input  logic           rst,
   sysmgr_reboot_if.slave bus
);
   localparam int                 PCNT_W     = pulse_cnt_w(PULSE_LEN);
   localparam logic [PCNT_W-1:0]  PULSE_INIT = PCNT_W'(PULSE_LEN);
   localparam logic [PCNT_W-1:0]  PULSE_ONE  = PCNT_W'(1);
   localparam logic [DELAY_W-1:0] DELAY_ONE  = DELAY_W'(1);

   state_e             state_q;
   logic [DELAY_W-1:0] cnt_q;
   logic [PCNT_W-1:0]  pcnt_q;
   logic               busy_q;
   logic               pll_rst_q;
   logic               trig_rise;
   logic               cancel_rise;
   logic               start_req;
   logic               hold_done;
   logic               go_boot;

   sysmgr_reboot_sync u_sync_trig (
      .clk        (clk),
      .rst        (rst),
      .async_in   (bus.req_trig),
      .rise_pulse (trig_rise)
   );

   sysmgr_reboot_sync u_sync_cancel (
      .clk        (clk),
      .rst        (rst),
      .async_in   (bus.req_cancel),
      .rise_pulse (cancel_rise)
   );

   // Cancel takes priority over the terminal count in the same cycle.
   assign start_req = (state_q == ST_IDLE) && trig_rise;
   assign hold_done = (start_req && (bus.req_delay == '0)) ||
                      ((state_q == ST_ARMED) && !cancel_rise && (cnt_q == DELAY_ONE));

`ifdef SYSMGR_REBOOT_WARMBOOT_EN
   logic       mode_q;
   logic [1:0] sel_q;
   logic [1:0] boot_sel_q;
   logic       boot_trig_q;

   assign go_boot = start_req ? (bus.req_mode == MODE_BOOT) : (mode_q == MODE_BOOT);

   // Select is loaded on BOOT entry, trigger follows a cycle later so S1:S0 settle first.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q      <= MODE_RST;
         sel_q       <= '0;
         boot_sel_q  <= '0;
         boot_trig_q <= 1'b0;
      end else begin
         if (start_req) begin
            mode_q <= bus.req_mode;
            sel_q  <= bus.req_sel;
         end
         if (hold_done && go_boot) begin
            boot_sel_q <= start_req ? bus.req_sel : sel_q;
         end
         if (state_q == ST_BOOT) begin
            boot_trig_q <= 1'b1;
         end
      end
   end

   SB_WARMBOOT u_warmboot (
      .BOOT (boot_trig_q),
      .S1   (boot_sel_q[1]),
      .S0   (boot_sel_q[0])
   );

   assign bus.boot_sel  = boot_sel_q;
   assign bus.boot_trig = boot_trig_q;
`else
   logic unused_mode_sel;

   assign unused_mode_sel = ^{bus.req_mode, bus.req_sel};
   assign go_boot         = 1'b0;
   assign bus.boot_sel    = 2'b00;
   assign bus.boot_trig   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         pcnt_q    <= '0;
         busy_q    <= 1'b0;
         pll_rst_q <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               pll_rst_q <= 1'b0;
               if (trig_rise) begin
                  state_q <= ST_ARMED;
                  cnt_q   <= bus.req_delay;
                  busy_q  <= 1'b1;
               end
            end
            ST_ARMED: begin
               if (cancel_rise) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else if (cnt_q != '0) begin
                  cnt_q <= cnt_q - DELAY_ONE;
               end
            end
            ST_FIRE: begin
               if (pcnt_q != '0) begin
                  pcnt_q <= pcnt_q - PULSE_ONE;
               end
               if (pcnt_q == PULSE_ONE) begin
                  state_q   <= ST_IDLE;
                  pll_rst_q <= 1'b0;
                  busy_q    <= 1'b0;
               end
            end
`ifdef SYSMGR_REBOOT_WARMBOOT_EN
            ST_BOOT: begin
               pll_rst_q <= 1'b0;
               busy_q    <= 1'b1;
            end
`endif
            default: begin
               state_q   <= ST_IDLE;
               pll_rst_q <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase

         if (hold_done) begin
            busy_q <= 1'b1;
            if (go_boot) begin
               state_q <= ST_BOOT;
            end else begin
               state_q   <= ST_FIRE;
               pll_rst_q <= 1'b1;
               pcnt_q    <= PULSE_INIT;
            end
         end
      end
   end

   assign bus.busy        = busy_q;
   assign bus.pll_rst_out = pll_rst_q;

endmodule

// File: tb/tb_sysmgr_reboot_ctrl.sv
// Self-checking bench for sysmgr_reboot_ctrl: expected busy/pll/boot waveforms are derived
// from request timing windows (accept latency, hold-off length, pulse length, cancel point).
module tb_sysmgr_reboot_ctrl;
   localparam int DELAY_W = 16;
   localparam int P       = 16;
   localparam int ACC     = 3;  // cycles from async rise to the request being taken

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   sysmgr_reboot_if #(.DELAY_W(DELAY_W)) bus ();

   sysmgr_reboot_ctrl #(.DELAY_W(DELAY_W), .PULSE_LEN(P)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   // One request of delay d; cancel/retrigger lines raised at cycle offsets c_at/r_at (-1 = none).
   task automatic run_request(input string tag, input int d, input int c_at, input int r_at);
      int busy_hi, pll_lo, pll_hi, span, last;
      logic [4:0] obs, exp;
      busy_hi = ACC + d + P - 1;
      pll_lo  = ACC + d;
      pll_hi  = busy_hi;
      if (c_at >= 1 && d > 0 && (c_at + ACC) <= (ACC + d)) begin
         busy_hi = c_at + ACC - 1;
         pll_lo  = 1;
         pll_hi  = 0;
      end
      last = ACC + d + P;
      if (c_at > last) last = c_at;
      if (r_at > last) last = r_at;
      span = last + 8;
      bus.req_delay = DELAY_W'(d);
      bus.req_mode  = 1'b0;
      bus.req_sel   = 2'($urandom_range(0, 3));
      for (int n = 0; n <= span; n++) begin
         if (n > 0) begin
            exp = {(n >= ACC && n <= busy_hi), (n >= pll_lo && n <= pll_hi), 1'b0, 2'b00};
            obs = {bus.busy, bus.pll_rst_out, bus.boot_trig, bus.boot_sel};
            checks++;
            if (obs !== exp) begin
               errors++;
               $display("FAIL %s d=%0d n=%0d {busy,pll,btrig,bsel} got %b want %b", tag, d, n, obs, exp);
            end
         end
         bus.req_trig   = (n < 4) || (r_at >= 0 && n >= r_at && n < r_at + 4);
         bus.req_cancel = (c_at >= 0 && n >= c_at && n < c_at + 4);
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      logic [4:0] obs;
      rst = 1'b1;
      bus.req_trig = 1'b0; bus.req_cancel = 1'b0; bus.req_mode = 1'b0;
      bus.req_sel = 2'b00; bus.req_delay = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         obs = {bus.busy, bus.pll_rst_out, bus.boot_trig, bus.boot_sel};
         checks++;
         if (obs !== 5'b01000) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d got %b want 01000", i, obs);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      obs = {bus.busy, bus.pll_rst_out, bus.boot_trig, bus.boot_sel};
      checks++;
      if (obs !== 5'b00000) begin
         errors++;
         $display("FAIL reset_release got %b want 00000", obs);
      end
   endtask

   task automatic test_basic();
      run_request("delay5", 5, -1, -1);
      run_request("delay0", 0, -1, -1);
      run_request("delay1", 1, -1, -1);
   endtask

   task automatic test_cancel();
      run_request("cancel_at40", 100, 40, -1);
      run_request("after_cancel", 7, -1, -1);
      run_request("cancel_at_cnt1", 3, 3, -1);
      run_request("cancel_in_fire", 3, 10, -1);
   endtask

   task automatic test_retrig();
      run_request("retrig_in_fire", 3, -1, 8);
      run_request("retrig_in_armed", 30, -1, 10);
   endtask

   task automatic test_random();
      int d, c_at, r_at;
      for (int k = 0; k < 8; k++) begin
         d    = int'($urandom_range(0, 40));
         c_at = -1;
         r_at = -1;
         if ($urandom_range(0, 1) == 1) c_at = int'($urandom_range(1, d + P + 2));
         else if ($urandom_range(0, 1) == 1) r_at = int'($urandom_range(6, d + P - 1));
         run_request("random", d, c_at, r_at);
      end
   endtask

   // rst asserted for one cycle at offset rst_at; the pending request must vanish.
   task automatic test_rst_mid(input string tag, input int d, input int rst_at);
      logic [4:0] obs, exp;
      bus.req_delay = DELAY_W'(d);
      bus.req_mode  = 1'b0;
      for (int n = 0; n <= rst_at + 30; n++) begin
         if (n > 0) begin
            if (n <= rst_at)
               exp = {(n >= ACC && n <= ACC + d + P - 1), (n >= ACC + d && n <= ACC + d + P - 1), 3'b000};
            else if (n == rst_at + 1)
               exp = 5'b01000;
            else
               exp = 5'b00000;
            obs = {bus.busy, bus.pll_rst_out, bus.boot_trig, bus.boot_sel};
            checks++;
            if (obs !== exp) begin
               errors++;
               $display("FAIL %s n=%0d got %b want %b", tag, n, obs, exp);
            end
         end
         bus.req_trig = (n < 4);
         rst          = (n == rst_at);
         @(negedge clk);
      end
   endtask

   task automatic test_warmboot();
      logic [4:0] obs, exp;
      bus.req_delay = DELAY_W'(2);
      bus.req_mode  = 1'b1;
      bus.req_sel   = 2'd2;
      for (int n = 0; n <= 40; n++) begin
         if (n > 0) begin
`ifdef SYSMGR_REBOOT_WARMBOOT_EN
            exp = {(n >= ACC), 1'b0, (n >= ACC + 3), ((n >= ACC + 2) ? 2'd2 : 2'd0)};
`else
            exp = {(n >= ACC && n <= ACC + 2 + P - 1), (n >= ACC + 2 && n <= ACC + 2 + P - 1), 3'b000};
`endif
            obs = {bus.busy, bus.pll_rst_out, bus.boot_trig, bus.boot_sel};
            checks++;
            if (obs !== exp) begin
               errors++;
               $display("FAIL warmboot n=%0d got %b want %b", n, obs, exp);
            end
         end
         bus.req_trig = (n < 4);
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      obs = {bus.busy, bus.pll_rst_out, bus.boot_trig, bus.boot_sel};
      checks++;
      if (obs !== 5'b01000) begin
         errors++;
         $display("FAIL warmboot_rst got %b want 01000", obs);
      end
      rst = 1'b0;
      bus.req_mode = 1'b0;
      @(negedge clk);
      obs = {bus.busy, bus.pll_rst_out, bus.boot_trig, bus.boot_sel};
      checks++;
      if (obs !== 5'b00000) begin
         errors++;
         $display("FAIL warmboot_release got %b want 00000", obs);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_cancel();
      test_retrig();
      test_random();
      test_rst_mid("rst_in_armed", 20, 10);
      test_rst_mid("rst_in_fire", 8, 16);
      test_warmboot();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
